// File: rtl/program_loader_pkg.sv
// Constants shared by the loader and the CPU: state encodings, the default
// instruction-memory depth and the big-endian byte-shift helper.
package program_loader_pkg;

    localparam int INSTR_MEM_SIZE_DEFAULT = 32;

    typedef enum logic [2:0] {
        LOADER_IDLE  = 3'd0,
        LOADER_LOAD  = 3'd1,
        LOADER_WRITE = 3'd2,
        LOADER_DONE  = 3'd3,
        LOADER_ERROR = 3'd4
    } loader_state_e;

    function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                  input logic [7:0]  new_byte);
        return {word[23:0], new_byte};
    endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// Collects four bytes into a big-endian word; word_ready_o flags the edge on
// which the fourth byte is being accepted, with word_o already including it.
module program_loader_byte_packer
    import program_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        shift_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  count_q, count_d;

    // Next-state for the shift register and byte counter; clear wins over shift.
    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (clear_i) begin
            shift_d = 32'd0;
            count_d = 2'd0;
        end else if (shift_en_i) begin
            shift_d = shift_in_byte(shift_q, byte_i);
            count_d = count_q + 2'd1;
        end else begin
            shift_d = shift_q;
            count_d = count_q;
        end
    end

    // Shift register and byte counter state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q <= 32'd0;
            count_q <= 2'd0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    assign word_o       = shift_in_byte(shift_q, byte_i);
    assign word_ready_o = shift_en_i && !clear_i && (count_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Streams a byte-wise program into the instruction memory write port and
// holds the CPU in reset until every word has been written.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int INSTR_MEM_SIZE = INSTR_MEM_SIZE_DEFAULT,
    parameter int ADDR_WIDTH     = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   n_words,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  imem_write,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_data,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0]   MEM_DEPTH = (ADDR_WIDTH + 1)'(INSTR_MEM_SIZE);
    localparam logic [ADDR_WIDTH:0]   ONE_N     = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_IDX   = ADDR_WIDTH'(1);

    loader_state_e         state_q;
    logic [ADDR_WIDTH:0]   n_words_q;
    logic [ADDR_WIDTH-1:0] word_idx_q;
    logic [ADDR_WIDTH-1:0] imem_addr_q;
    logic [31:0]           imem_data_q;
    logic                  done_q;
    logic                  error_q;
    logic                  cpu_reset_n_q;

    logic                  start_ok_s;
    logic                  shift_en_s;
    logic                  last_word_s;
    logic [31:0]           packed_word_s;
    logic                  word_ready_s;

    // A start is only honoured when no load is in flight.
    always_comb begin
        start_ok_s = 1'b0;
        case (state_q)
            LOADER_IDLE, LOADER_DONE, LOADER_ERROR: start_ok_s = start;
            default:                                start_ok_s = 1'b0;
        endcase
    end

    assign shift_en_s  = byte_valid && (state_q == LOADER_LOAD);
    assign last_word_s = ({1'b0, word_idx_q} == (n_words_q - ONE_N));

    program_loader_byte_packer u_packer (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (start_ok_s),
        .shift_en_i   (shift_en_s),
        .byte_i       (byte_in),
        .word_o       (packed_word_s),
        .word_ready_o (word_ready_s)
    );

    // Loader FSM with its registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= LOADER_IDLE;
            n_words_q     <= '0;
            word_idx_q    <= '0;
            imem_addr_q   <= '0;
            imem_data_q   <= 32'd0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            cpu_reset_n_q <= 1'b0;
        end else begin
            case (state_q)
                LOADER_IDLE, LOADER_DONE, LOADER_ERROR: begin
                    if (start_ok_s) begin
                        n_words_q  <= n_words;
                        word_idx_q <= '0;
                        if (n_words > MEM_DEPTH) begin
                            state_q       <= LOADER_ERROR;
                            error_q       <= 1'b1;
                            done_q        <= 1'b0;
                            cpu_reset_n_q <= 1'b0;
                        end else if (n_words == '0) begin
                            // Empty program: nothing to hold the CPU for.
                            state_q       <= LOADER_DONE;
                            error_q       <= 1'b0;
                            done_q        <= 1'b1;
                            cpu_reset_n_q <= 1'b1;
                        end else begin
                            state_q       <= LOADER_LOAD;
                            error_q       <= 1'b0;
                            done_q        <= 1'b0;
                            cpu_reset_n_q <= 1'b0;
                        end
                    end
                end
                LOADER_LOAD: begin
                    if (word_ready_s) begin
                        state_q     <= LOADER_WRITE;
                        imem_addr_q <= word_idx_q;
                        imem_data_q <= packed_word_s;
                    end
                end
                LOADER_WRITE: begin
                    if (last_word_s) begin
                        state_q       <= LOADER_DONE;
                        done_q        <= 1'b1;
                        cpu_reset_n_q <= 1'b1;
                    end else begin
                        state_q    <= LOADER_LOAD;
                        word_idx_q <= word_idx_q + ONE_IDX;
                    end
                end
                default: begin
                    state_q       <= LOADER_IDLE;
                    done_q        <= 1'b0;
                    error_q       <= 1'b0;
                    cpu_reset_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready  = (state_q == LOADER_LOAD);
    assign imem_write  = (state_q == LOADER_WRITE);
    assign busy        = (state_q == LOADER_LOAD) || (state_q == LOADER_WRITE);
    assign imem_addr   = imem_addr_q;
    assign imem_data   = imem_data_q;
    assign done        = done_q;
    assign error       = error_q;
    assign cpu_reset_n = cpu_reset_n_q;

endmodule

// File: tb/tb_program_loader.sv
// Table-driven and randomized checks of program_loader against a word-level model.
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  n_words;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_write;
    logic [4:0]  imem_addr;
    logic [31:0] imem_data;
    logic        cpu_reset_n;
    logic        busy;
    logic        done;
    logic        error;

    program_loader dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .n_words     (n_words),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .imem_write  (imem_write),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .cpu_reset_n (cpu_reset_n),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    logic [31:0] tb_mem [32];
    int          wr_total = 0;

    always @(posedge clock) begin
        if (imem_write) begin
            tb_mem[imem_addr] <= imem_data;
            wr_total          <= wr_total + 1;
        end
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  stim  [$];
    logic [31:0] exp_q [$];

    typedef struct {
        int          n;
        int          mode;
        bit          exp_err;
        int          exp_cycles;
        logic [63:0] bytes;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs [5];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, " cpu_reset_n"}, cpu_reset_n, 1'b0);
        chk1({tag, " done"}, done, 1'b0);
        chk1({tag, " error"}, error, 1'b0);
        chk1({tag, " busy"}, busy, 1'b0);
        chk1({tag, " byte_ready"}, byte_ready, 1'b0);
        chk1({tag, " imem_write"}, imem_write, 1'b0);
        chk32({tag, " imem_addr"}, 32'(imem_addr), 32'd0);
        chk32({tag, " imem_data"}, imem_data, 32'd0);
    endtask

    // mode 0: valid always high, 1: valid on alternate cycles, 2: random valid plus stray starts.
    task automatic run_load(input string name, input int n, input int mode,
                            input bit exp_err, input int exp_cycles);
        int cyc;
        int acc;
        int k;
        int wr_before;
        wr_before = wr_total;
        @(negedge clock);
        start      = 1'b1;
        n_words    = 6'(n);
        byte_valid = 1'b0;
        @(negedge clock);
        start = 1'b0;
        cyc   = 1;
        acc   = 0;
        k     = 0;
        while (!(done || error) && cyc < 2000) begin
            chk1({name, " busy in load"}, busy, 1'b1);
            chk1({name, " cpu held in load"}, cpu_reset_n, 1'b0);
            if (imem_write) begin
                chk32({name, " write addr"}, 32'(imem_addr), 32'(k));
                chk32({name, " write data"}, imem_data, (k < exp_q.size()) ? exp_q[k] : 32'hDEAD_BEEF);
                chk32({name, " bytes before write"}, 32'(acc), 32'(4 * (k + 1)));
                chk1({name, " no ready in write"}, byte_ready, 1'b0);
                k++;
            end
            case (mode)
                0:       byte_valid = 1'b1;
                1:       byte_valid = cyc[0];
                default: byte_valid = 1'($urandom_range(0, 1));
            endcase
            byte_in = (acc < stim.size()) ? stim[acc] : 8'($urandom);
            if (byte_valid && byte_ready) acc++;
            start   = (mode == 2) && busy && ($urandom_range(0, 7) == 0);
            n_words = 6'($urandom_range(0, 63));
            @(negedge clock);
            cyc++;
        end
        start      = 1'b0;
        byte_valid = 1'b0;
        chk1({name, " finished in budget"}, 1'(cyc < 2000), 1'b1);
        chk1({name, " error"}, error, exp_err);
        chk1({name, " done"}, done, !exp_err);
        chk1({name, " cpu_reset_n"}, cpu_reset_n, !exp_err);
        chk1({name, " busy after"}, busy, 1'b0);
        chk32({name, " write count"}, 32'(k), exp_err ? 32'd0 : 32'(n));
        chk32({name, " bytes consumed"}, 32'(acc), exp_err ? 32'd0 : 32'(4 * n));
        if (exp_cycles != 0) chk32({name, " cycles to finish"}, 32'(cyc), 32'(exp_cycles));
        if (!exp_err) begin
            for (int i = 0; i < n; i++) chk32({name, " memory word"}, tb_mem[i], exp_q[i]);
        end
        repeat (3) @(negedge clock);
        chk32({name, " no writes after end"}, 32'(wr_total - wr_before), exp_err ? 32'd0 : 32'(n));
        chk1({name, " state held"}, done, !exp_err);
    endtask

    initial begin
        logic [63:0] tmp;
        int          acc;
        int          wrote;
        reset      = 1'b0;
        start      = 1'b0;
        n_words    = 6'd0;
        byte_in    = 8'h00;
        byte_valid = 1'b1;

        vecs[0] = '{2, 0, 1'b0, 11, 64'h2009_0001_2012_000C, 32'h2009_0001, 32'h2012_000C};
        vecs[1] = '{2, 1, 1'b0, 0,  64'h2009_0001_2012_000C, 32'h2009_0001, 32'h2012_000C};
        vecs[2] = '{33, 0, 1'b1, 1, 64'h0, 32'h0, 32'h0};
        vecs[3] = '{1, 0, 1'b0, 6,  64'hAC12_0010_0000_0000, 32'hAC12_0010, 32'h0};
        vecs[4] = '{0, 0, 1'b0, 1,  64'h0, 32'h0, 32'h0};

        // Reset held, then released with no start: CPU stays held, nothing consumed.
        repeat (3) @(negedge clock);
        check_reset_outputs("in reset");
        reset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            check_reset_outputs("idle no start");
        end

        foreach (vecs[v]) begin
            stim.delete();
            exp_q.delete();
            tmp = vecs[v].bytes;
            for (int j = 0; j < 8; j++) stim.push_back(tmp[63 - 8 * j -: 8]);
            exp_q.push_back(vecs[v].w0);
            exp_q.push_back(vecs[v].w1);
            run_load($sformatf("vec%0d", v), vecs[v].n, vecs[v].mode,
                     vecs[v].exp_err, vecs[v].exp_cycles);
        end

        // Randomized loads against the word-level model.
        for (int r = 0; r < 7; r++) begin
            int n;
            int mode;
            logic [31:0] w;
            n    = (r == 0) ? 32 : $urandom_range(1, 32);
            mode = $urandom_range(0, 2);
            stim.delete();
            exp_q.delete();
            for (int j = 0; j < 4 * n; j++) stim.push_back(8'($urandom));
            for (int i = 0; i < n; i++) begin
                w = 32'd0;
                for (int b = 0; b < 4; b++) w = (w << 8) | 32'(stim[4 * i + b]);
                exp_q.push_back(w);
            end
            run_load($sformatf("rand%0d", r), n, mode, 1'b0, (mode == 0) ? 1 + 5 * n : 0);
        end

        // Reset after 6 of 8 bytes of a two-word load.
        stim.delete();
        exp_q.delete();
        tmp = 64'h2009_0001_2012_000C;
        for (int j = 0; j < 8; j++) stim.push_back(tmp[63 - 8 * j -: 8]);
        exp_q.push_back(32'h2009_0001);
        exp_q.push_back(32'h2012_000C);
        @(negedge clock);
        start   = 1'b1;
        n_words = 6'd2;
        @(negedge clock);
        start = 1'b0;
        acc   = 0;
        wrote = 0;
        for (int c = 0; c < 20 && acc < 6; c++) begin
            if (imem_write) begin
                chk32("midreset write addr", 32'(imem_addr), 32'd0);
                chk32("midreset write data", imem_data, 32'h2009_0001);
                wrote++;
            end
            byte_valid = 1'b1;
            byte_in    = stim[acc];
            if (byte_ready) acc++;
            @(negedge clock);
        end
        byte_valid = 1'b0;
        chk32("midreset writes before reset", 32'(wrote), 32'd1);
        chk1("midreset still busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("async reset");
        chk32("midreset word0 kept", tb_mem[0], 32'h2009_0001);
        @(negedge clock);
        reset = 1'b1;
        run_load("reload", 2, 0, 1'b0, 11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
